// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 read ports, 2 write ports, x0 hardwired to zero,
// optional write-to-read bypass, per-register busy scoreboard and sticky conflict flag.
module reg_file_mp #(
  parameter int N      = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] reg_read1,
  input  logic [ADDR_W-1:0] reg_read2,
  output logic [N-1:0]      read_data_1,
  output logic [N-1:0]      read_data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              write_enable1,
  input  logic [ADDR_W-1:0] reg_write1,
  input  logic [N-1:0]      write_data1,
  input  logic              write_enable2,
  input  logic [ADDR_W-1:0] reg_write2,
  input  logic [N-1:0]      write_data2,
  input  logic              issue_enable,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              conflict
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [N-1:0]     regs_q [DEPTH];
  logic [N-1:0]     regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;

  // One-hot per-register decode; entry 0 never hits, which keeps x0 at zero
  // and excludes it from bypass and scoreboard updates.
  logic [DEPTH-1:0] wr_hit1, wr_hit2, iss_hit;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_dec
      if (gi == 0) begin : g_zero
        assign wr_hit1[gi] = 1'b0;
        assign wr_hit2[gi] = 1'b0;
        assign iss_hit[gi] = 1'b0;
      end else begin : g_live
        assign wr_hit1[gi] = write_enable1 && (reg_write1 == ADDR_W'(gi));
        assign wr_hit2[gi] = write_enable2 && (reg_write2 == ADDR_W'(gi));
        assign iss_hit[gi] = issue_enable  && (issue_reg  == ADDR_W'(gi));
      end
    end
  endgenerate

  // Port 2 carries the younger instruction, so it wins the register update;
  // an issue supersedes a completing write for the busy bit.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (wr_hit2[i]) begin
        regs_d[i] = write_data2;
      end else if (wr_hit1[i]) begin
        regs_d[i] = write_data1;
      end
      if (iss_hit[i]) begin
        busy_d[i] = 1'b1;
      end else if (wr_hit1[i] || wr_hit2[i]) begin
        busy_d[i] = 1'b0;
      end
    end
    conflict_d = conflict_q || ((wr_hit1 & wr_hit2) != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    read_data_1 = regs_q[reg_read1];
    read_data_2 = regs_q[reg_read2];
    busy_1      = busy_q[reg_read1];
    busy_2      = busy_q[reg_read2];
    if (BYPASS != 0) begin
      if (wr_hit2[reg_read1]) begin
        read_data_1 = write_data2;
      end else if (wr_hit1[reg_read1]) begin
        read_data_1 = write_data1;
      end
      if (wr_hit2[reg_read2]) begin
        read_data_2 = write_data2;
      end else if (wr_hit1[reg_read2]) begin
        read_data_2 = write_data1;
      end
      // A same-cycle issue only shows up on busy after the edge.
      if ((wr_hit1[reg_read1] || wr_hit2[reg_read1]) && !iss_hit[reg_read1]) begin
        busy_1 = 1'b0;
      end
      if ((wr_hit1[reg_read2] || wr_hit2[reg_read2]) && !iss_hit[reg_read2]) begin
        busy_2 = 1'b0;
      end
    end
  end

  assign conflict = conflict_q;

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined RISC-V core: 2 read ports, 2 write ports, and a register 0 hardwired to zero.
- Adds optional write-to-read bypass, so a write and a read of the same register in one cycle return the new value.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback), which the hazard unit uses for stall decisions.
- Adds a sticky write-conflict flag.
- Replaces the single-write-port register file in the decode/writeback stages.

Parameters:
N, 32, data width of each register in bits
ADDR_W, 5, register address width; depth = 2**ADDR_W registers
BYPASS, 1, 1 = writes forwarded to same-cycle reads and busy outputs; 0 = reads show pre-edge contents only

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
reg_read1  input  ADDR_W  read port 1 address
reg_read2  input  ADDR_W  read port 2 address
read_data_1  output  N  read port 1 data (combinational)
read_data_2  output  N  read port 2 data (combinational)
busy_1  output  1  scoreboard busy bit for reg_read1 (combinational)
busy_2  output  1  scoreboard busy bit for reg_read2 (combinational)
write_enable1  input  1  write port 1 enable
reg_write1  input  ADDR_W  write port 1 address
write_data1  input  N  write port 1 data
write_enable2  input  1  write port 2 enable
reg_write2  input  ADDR_W  write port 2 address
write_data2  input  N  write port 2 data
issue_enable  input  1  mark issue_reg busy (new in-flight producer)
issue_reg  input  ADDR_W  destination register being issued
conflict  output  1  sticky flag: both write ports hit the same nonzero register in one cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On a rising clk edge with reset=1, every register clears to 0, every busy bit clears to 0, and conflict clears to 0. Writes and issues in that cycle are ignored.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues addressed to 0 are discarded.
  - A write to 0 never raises conflict.
- Write latency: write_data lands at the rising edge where write_enableX=1. With BYPASS=0, it is visible on read_data from the following cycle.
- Dual write, same nonzero register, same cycle: port 2 wins (the younger instruction). Port 1's data is dropped, and conflict is set on that edge. conflict stays 1 until reset.
- Bypass (BYPASS=1): if reg_readK equals an enabled, nonzero reg_writeX in the current cycle, read_data_K returns that write's data.
  - Port 2 has priority over port 1, matching the register-update priority.
  - Never bypass for register 0.
- Scoreboard busy bit per register, updated at the rising edge:
  - Cleared when any enabled write targets the register.
  - Set when issue_enable=1 and issue_reg equals the register.
  - If a set and a clear hit the same register in the same cycle, set wins (the new producer supersedes the completing one).
- busy_K:
  - Reflects the registered busy bit for reg_readK.
  - With BYPASS=1, it reads 0 if an enabled write to that register occurs this cycle and no same-register issue occurs this cycle.
  - A same-cycle issue is not visible on busy_K until the next cycle.
- Read ports are purely combinational from the addresses and state; no read enable.
- Write data is stored with full N-bit width; no width conversion.
- Reset mid-operation: any pending busy bits are lost; software/pipeline flush is expected alongside reset.
- Unknown or out-of-range inputs: none; every ADDR_W address is valid.

Test Plan:
- Reset: assert reset 1 cycle after random writes -> all read_data = 0, busy_1 = busy_2 = 0, conflict = 0.
- Basic write/read, BYPASS=0: write x5 = 0xDEADBEEF, reg_read1 = 5 in the same cycle -> old value (0). Next cycle -> 0xDEADBEEF.
- Bypass, BYPASS=1:
  - write x7 = 0x12345678 with reg_read2 = 7 in the same cycle -> read_data_2 = 0x12345678 immediately.
  - write x0 = 0xFFFFFFFF -> reads of x0 stay 0.
- Dual-write collision: port 1 writes x3 = 0xAAAA0000 and port 2 writes x3 = 0x0000BBBB in the same cycle -> x3 = 0x0000BBBB and conflict = 1, held until reset. Both ports writing x0 -> conflict stays 0.
- Scoreboard sequence:
  - issue x9 -> busy on x9 = 1 next cycle.
  - write x9 -> busy_1 = 0 same cycle (bypass) and 0 thereafter.
  - issue x9 and write x9 in the same cycle -> x9 stays busy = 1.
  - issue x0 -> busy stays 0.
- Parameter sweep: N=64, ADDR_W=4 -> 16 registers, 64-bit write/read of 0x0123456789ABCDEF to x15 correct, no aliasing with x0–x14.
